// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int              XLEN               = 32;
   localparam logic [XLEN-1:0] NOP_INST           = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {inst, pc} entries; flush beats push and pop.
// Head entry is read combinationally so decode sees it with no extra latency.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_data,
   output fetch_entry_t rd_data,
   output logic         full,
   output logic         empty,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign rd_data = mem_reg[rd_ptr_reg];

   // A push into a full FIFO is legal only when the head leaves the same cycle.
   assign do_push = push && !flush && (!full || pop);
   assign do_pop  = pop && !flush && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= wr_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response buffering.
// Define FETCH_BUBBLE_CNT_EN to add the o_bubble_cnt decode-starvation counter.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic            o_imem_req_valid,
   input  logic            i_imem_req_ready,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_rsp_valid,
   input  logic [XLEN-1:0] i_imem_rsp_data,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_inst_valid,
   input  logic            i_inst_ready,
   output logic [XLEN-1:0] o_inst,
   output logic [XLEN-1:0] o_inst_pc
`ifdef FETCH_BUBBLE_CNT_EN
  ,output logic [XLEN-1:0] o_bubble_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic            started_reg;
   logic [XLEN-1:0] pc_reg,          pc_next;
   logic [CW-1:0]   outstanding_reg, outstanding_next;
   logic [CW-1:0]   drop_reg,        drop_next;

   logic [XLEN-1:0] aq_mem_reg [FIFO_DEPTH];
   logic [AW-1:0]   aq_wr_ptr_reg;
   logic [AW-1:0]   aq_rd_ptr_reg;

   logic            req_fire;
   logic            credit_ok;
   logic [CW:0]     slots_in_use;
   logic            inst_push;
   logic            inst_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    fifo_wr;
   fetch_entry_t    fifo_head;

   // Every accepted request reserves a FIFO slot, so responses never overflow.
   assign slots_in_use     = {1'b0, fifo_count} + {1'b0, outstanding_reg};
   assign credit_ok        = !fifo_full && (slots_in_use < (CW + 1)'(FIFO_DEPTH));
   assign o_imem_req_valid = started_reg && !i_redirect && credit_ok;
   assign o_imem_addr      = pc_reg;
   assign req_fire         = o_imem_req_valid && i_imem_req_ready;

   assign inst_push = i_imem_rsp_valid && !i_redirect && (drop_reg == '0);
   assign inst_pop  = o_inst_valid && i_inst_ready;
   assign fifo_wr   = '{inst: i_imem_rsp_data, pc: aq_mem_reg[aq_rd_ptr_reg]};

   always_comb begin
      pc_next          = pc_reg;
      drop_next        = drop_reg;
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(i_imem_rsp_valid);
      if (i_redirect) begin
         pc_next   = word_align(i_redirect_pc);
         drop_next = outstanding_reg - CW'(i_imem_rsp_valid);
      end else begin
         if (req_fire) pc_next = pc_reg + XLEN'(4);
         if (i_imem_rsp_valid && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         started_reg     <= 1'b0;
         pc_reg          <= RESET_ADDR;
         outstanding_reg <= '0;
         drop_reg        <= '0;
      end else begin
         started_reg     <= 1'b1;
         pc_reg          <= pc_next;
         outstanding_reg <= outstanding_next;
         drop_reg        <= drop_next;
      end
   end

   // Issued-address queue: every response, kept or dropped, retires one entry.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         aq_wr_ptr_reg <= '0;
         aq_rd_ptr_reg <= '0;
      end else begin
         if (req_fire)         aq_wr_ptr_reg <= aq_wr_ptr_reg + 1'b1;
         if (i_imem_rsp_valid) aq_rd_ptr_reg <= aq_rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (req_fire) aq_mem_reg[aq_wr_ptr_reg] <= pc_reg;
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_inst_fifo (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .push    (inst_push),
      .pop     (inst_pop),
      .flush   (i_redirect),
      .wr_data (fifo_wr),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign o_inst_valid = !fifo_empty;
   assign o_inst       = fifo_empty ? NOP_INST   : fifo_head.inst;
   assign o_inst_pc    = fifo_empty ? RESET_ADDR : fifo_head.pc;

`ifdef FETCH_BUBBLE_CNT_EN
   logic [XLEN-1:0] bubble_cnt_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bubble_cnt_reg <= '0;
      end else if (i_redirect) begin
         bubble_cnt_reg <= '0;
      end else if (started_reg && !o_inst_valid && (bubble_cnt_reg != '1)) begin
         bubble_cnt_reg <= bubble_cnt_reg + XLEN'(1);
      end
   end

   assign o_bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a program-order reference model.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RA = 32'h0000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_inst_valid;
   logic        i_inst_ready;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
`ifdef FETCH_BUBBLE_CNT_EN
   logic [31:0] o_bubble_cnt;
`endif

   fetch_unit #(.RESET_ADDR(RA), .FIFO_DEPTH(2)) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_addr      (o_imem_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .i_redirect       (i_redirect),
      .i_redirect_pc    (i_redirect_pc),
      .o_inst_valid     (o_inst_valid),
      .i_inst_ready     (i_inst_ready),
      .o_inst           (o_inst),
      .o_inst_pc        (o_inst_pc)
`ifdef FETCH_BUBBLE_CNT_EN
     ,.o_bubble_cnt     (o_bubble_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   int          n_pass = 0;
   int          n_fail = 0;
   int          n_checks = 0;
   longint      cyc = 0;
   longint      last_due = -1;
   logic [31:0] q_addr[$];
   longint      q_due[$];
   logic [31:0] cons_log[$];
   int          lat_min = 1, lat_max = 1;
   int          ready_pct = 100, dec_pct = 100;
   logic [31:0] exp_req = RA;
   logic [31:0] exp_pc  = RA;
   int          n_consumed = 0;
   bit          found;

   // Imem contents: a fixed scramble of the address, so data identifies its PC.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge: present imem response and handshake inputs.
   task automatic drive_inputs();
      i_redirect       = 1'b0;
      i_imem_req_ready = ($urandom_range(99) < ready_pct);
      i_inst_ready     = ($urandom_range(99) < dec_pct);
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
         i_imem_rsp_valid = 1'b1;
         i_imem_rsp_data  = mem_word(q_addr[0]);
      end else begin
         i_imem_rsp_valid = 1'b0;
         i_imem_rsp_data  = $urandom;
      end
      #2;
   endtask

   // Sample the cycle, clock it, then advance the imem and program-order models.
   task automatic finish_cycle();
      bit          fire, cons, redir, rsp;
      logic [31:0] addr, rpc, ipc;
      longint      due;
      #1;
      fire  = o_imem_req_valid && i_imem_req_ready;
      cons  = o_inst_valid && i_inst_ready;
      redir = i_redirect;
      rsp   = i_imem_rsp_valid;
      addr  = o_imem_addr;
      rpc   = i_redirect_pc;
      ipc   = o_inst_pc;
      if (redir) check("no_req_on_redirect", o_imem_req_valid, 0);
      if (o_inst_valid) begin
         check("head_pc", o_inst_pc, exp_pc);
         check("head_inst", o_inst, mem_word(exp_pc));
      end
      if (fire) check("req_addr", addr, exp_req);
      @(posedge i_clk);
      #1;
      if (rsp) begin
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
      if (fire) begin
         due = cyc + longint'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         q_addr.push_back(addr);
         q_due.push_back(due);
      end
      cyc++;
      if (redir) begin
         exp_req = {rpc[31:2], 2'b00};
         exp_pc  = {rpc[31:2], 2'b00};
      end else begin
         if (fire) exp_req = exp_req + 32'd4;
         if (cons) begin
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
            cons_log.push_back(ipc);
         end
      end
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         drive_inputs();
         finish_cycle();
      end
   endtask

   task automatic run_until_consumed(input int n, input int budget);
      int k = 0;
      while (n_consumed < n && k < budget) begin
         drive_inputs();
         finish_cycle();
         k++;
      end
      check("consume_timeout", n_consumed >= n, 1);
   endtask

   task automatic model_reset();
      q_addr.delete();
      q_due.delete();
      last_due = -1;
      cyc      = 0;
      exp_req  = RA;
      exp_pc   = RA;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0;
      i_redirect = 1'b0; i_redirect_pc = '0; i_inst_ready = 1'b0;
      #1;
      check("rst_req_valid", o_imem_req_valid, 0);
      check("rst_inst_valid", o_inst_valid, 0);
      check("rst_inst", o_inst, NOP_INST);
      check("rst_inst_pc", o_inst_pc, RA);
`ifdef FETCH_BUBBLE_CNT_EN
      check("rst_bubble", o_bubble_cnt, 0);
`endif
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      model_reset();

      // Startup: no request before the started flag, then fetch from RESET_ADDR.
      drive_inputs();
      check("pre_start_req", o_imem_req_valid, 0);
      finish_cycle();
      drive_inputs();
      check("first_req_valid", o_imem_req_valid, 1);
      check("first_req_addr", o_imem_addr, RA);
      finish_cycle();

      // Streaming with 1-cycle imem and always-ready decode.
      n_consumed = 0;
      cons_log.delete();
      run_cycles(30);
      check("stream_rate", n_consumed >= 16, 1);
      check("stream_pc0", cons_log[0], 32'h0);
      check("stream_pc1", cons_log[1], 32'h4);
      check("stream_pc2", cons_log[2], 32'h8);

      // Decode stall: FIFO fills and requests stop.
      dec_pct = 0;
      run_cycles(10);
      drive_inputs();
      check("stall_req_valid", o_imem_req_valid, 0);
      check("stall_inst_valid", o_inst_valid, 1);
      check("stall_outstanding", q_due.size(), 0);
      finish_cycle();
      dec_pct = 100;
      run_cycles(10);

      // Redirect to 0x100 with two responses in flight.
      lat_min = 3; lat_max = 3;
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         drive_inputs();
         if (q_due.size() == 2 && !i_imem_rsp_valid) begin
            i_redirect = 1'b1; i_redirect_pc = 32'h100; found = 1;
         end
         finish_cycle();
      end
      check("redir100_found", found, 1);
      n_consumed = 0;
      cons_log.delete();
      run_until_consumed(1, 30);
      check("redir100_first_pc", cons_log[0], 32'h100);
      run_cycles(10);

      // Redirect to 0x203 while a response arrives and decode pops.
      lat_min = 1; lat_max = 1;
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         drive_inputs();
         if (i_imem_rsp_valid && o_inst_valid && i_inst_ready) begin
            i_redirect = 1'b1; i_redirect_pc = 32'h203; found = 1;
         end
         finish_cycle();
      end
      check("redir203_found", found, 1);
      check("redir203_empty", o_inst_valid, 0);
      drive_inputs();
      check("redir203_req_valid", o_imem_req_valid, 1);
      check("redir203_req_addr", o_imem_addr, 32'h200);
      finish_cycle();
      run_cycles(10);

      // PC wrap at the top of the address space.
      drive_inputs();
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
      finish_cycle();
      n_consumed = 0;
      cons_log.delete();
      run_until_consumed(2, 30);
      check("wrap_pc0", cons_log[0], 32'hFFFF_FFFC);
      check("wrap_pc1", cons_log[1], 32'h0000_0000);

      // Randomized traffic with occasional redirects.
      ready_pct = 70; dec_pct = 70; lat_min = 1; lat_max = 4;
      n_consumed = 0;
      for (int k = 0; k < 600; k++) begin
         drive_inputs();
         if ($urandom_range(99) < 5) begin
            i_redirect = 1'b1; i_redirect_pc = $urandom;
         end
         finish_cycle();
      end
      check("random_progress", n_consumed > 50, 1);

      // Reset mid-stream with a non-empty FIFO.
      ready_pct = 100; dec_pct = 0; lat_min = 1; lat_max = 1;
      found = 0;
      for (int k = 0; k < 30 && !found; k++) begin
         drive_inputs();
         found = o_inst_valid;
         finish_cycle();
      end
      check("midrst_fifo_nonempty", found, 1);
      i_rst_n = 1'b0;
      #1;
      check("midrst_inst_valid", o_inst_valid, 0);
      check("midrst_req_valid", o_imem_req_valid, 0);
      check("midrst_inst", o_inst, NOP_INST);
      check("midrst_inst_pc", o_inst_pc, RA);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      model_reset();
      dec_pct = 100;
      drive_inputs();
      check("midrst_pre_start_req", o_imem_req_valid, 0);
      finish_cycle();
      drive_inputs();
      check("midrst_req_valid_after", o_imem_req_valid, 1);
      check("midrst_req_addr", o_imem_addr, RA);
      finish_cycle();
      n_consumed = 0;
      cons_log.delete();
      run_until_consumed(3, 30);
      check("midrst_first_pc", cons_log[0], RA);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
